// File: rtl/shm_pkg.sv
// Shared definitions for the shared-memory DMA requester: geometry, action codes,
// the request record carried through the command FIFO, and the requester FSM states.
package shm_pkg;

  localparam int SIZE        = 4;
  localparam int PROCSIZE    = 4;
  localparam int WORD_SIZE   = 16;
  localparam int PAGE_SIZE   = 2;
  localparam int PAGES_COUNT = SIZE - PAGE_SIZE;

  localparam logic ACT_READ  = 1'b0;
  localparam logic ACT_WRITE = 1'b1;

  typedef struct packed {
    logic                action;
    logic [SIZE-1:0]     ptr;
    logic [PROCSIZE-1:0] start;
    logic [PROCSIZE-1:0] length;
  } dma_req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } req_state_t;

endpackage

// File: rtl/shm_req_fifo.sv
// Two-entry command FIFO for the DMA requester. Push into a full FIFO and pop from
// an empty one are ignored, so the count can never leave 0..2.
module shm_req_fifo
  import shm_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  dma_req_t wdata,
  output dma_req_t rdata,
  output logic     full,
  output logic     empty
);

  dma_req_t   mem_r [2];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] count_r;
  logic       push_s;
  logic       pop_s;

  assign push_s = push & (count_r != 2'd2);
  assign pop_s  = pop & (count_r != 2'd0);

  // Storage, 1-bit wrapping pointers and occupancy count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);

endmodule

// File: rtl/shm_dma_requester.sv
// Processor-side initiator of the shared-memory DMA toggle protocol: queues copy
// commands, issues each by inverting trigger, and reports ack completion or timeout.
module shm_dma_requester #(
  parameter int SIZE           = 4,
  parameter int PROCSIZE       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [SIZE-1:0]     cmd_ptr,
  input  logic [PROCSIZE-1:0] cmd_start,
  input  logic [PROCSIZE-1:0] cmd_length,
  output logic                done_valid,
  output logic                done_timeout,
  output logic                busy,
  output logic                protocol_err,
  output logic                trigger,
  input  logic                ack,
  output logic                action,
  output logic [SIZE-1:0]     ptr,
  output logic [PROCSIZE-1:0] copy_start,
  output logic [PROCSIZE-1:0] copy_length
);

  import shm_pkg::*;

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] MAX_C = {CW{1'b1}};

  req_state_t    state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  dma_req_t      req_r, req_nxt_s;
  logic          trigger_r, trigger_nxt_s;
  logic          done_valid_r, done_valid_nxt_s;
  logic          done_timeout_r, done_timeout_nxt_s;
  logic          protocol_err_r, protocol_err_nxt_s;
  logic          last_ack_r;
  logic          ack_evt_s;

  dma_req_t      cmd_req_s;
  dma_req_t      head_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          push_s;
  logic          pop_s;

  assign cmd_req_s = {(cmd_write ? ACT_WRITE : ACT_READ), cmd_ptr, cmd_start, cmd_length};
  assign push_s    = cmd_valid & ~fifo_full_s;
  assign ack_evt_s = ack ^ last_ack_r;

  shm_req_fifo u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (cmd_req_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state, request launch and completion decode.
  always_comb begin
    state_nxt_s        = state_r;
    cnt_nxt_s          = cnt_r;
    req_nxt_s          = req_r;
    trigger_nxt_s      = trigger_r;
    done_valid_nxt_s   = 1'b0;
    done_timeout_nxt_s = 1'b0;
    protocol_err_nxt_s = protocol_err_r;
    pop_s              = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ack_evt_s) begin
          protocol_err_nxt_s = 1'b1;
        end else begin
          protocol_err_nxt_s = protocol_err_r;
        end
        if (!fifo_empty_s) begin
          pop_s = 1'b1;
          if (head_s.length != {PROCSIZE{1'b0}}) begin
            req_nxt_s     = head_s;
            trigger_nxt_s = ~trigger_r;
            cnt_nxt_s     = {CW{1'b0}};
            state_nxt_s   = ST_WAIT;
          end else begin
            // Zero-length copies complete locally without bothering the engine.
            done_valid_nxt_s = 1'b1;
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_WAIT: begin
        // An ack arriving on the timeout cycle still counts as a normal completion.
        if (ack_evt_s) begin
          done_valid_nxt_s = 1'b1;
          state_nxt_s      = ST_IDLE;
        end else if (cnt_r == TMO_C) begin
          done_valid_nxt_s   = 1'b1;
          done_timeout_nxt_s = 1'b1;
          state_nxt_s        = ST_DRAIN;
        end else if (cnt_r != MAX_C) begin
          cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_DRAIN: begin
        if (ack_evt_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and registered protocol outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      cnt_r          <= {CW{1'b0}};
      req_r          <= '0;
      trigger_r      <= 1'b0;
      done_valid_r   <= 1'b0;
      done_timeout_r <= 1'b0;
      protocol_err_r <= 1'b0;
      last_ack_r     <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      cnt_r          <= cnt_nxt_s;
      req_r          <= req_nxt_s;
      trigger_r      <= trigger_nxt_s;
      done_valid_r   <= done_valid_nxt_s;
      done_timeout_r <= done_timeout_nxt_s;
      protocol_err_r <= protocol_err_nxt_s;
      last_ack_r     <= ack;
    end
  end

  assign cmd_ready    = ~fifo_full_s;
  assign busy         = (state_r != ST_IDLE) | ~fifo_empty_s;
  assign done_valid   = done_valid_r;
  assign done_timeout = done_timeout_r;
  assign protocol_err = protocol_err_r;
  assign trigger      = trigger_r;
  assign action       = req_r.action;
  assign ptr          = req_r.ptr;
  assign copy_start   = req_r.start;
  assign copy_length  = req_r.length;

endmodule

// File: tb/tb_shm_dma_requester.sv
// Directed bench for shm_dma_requester: stimulus pushes expected requests/completions
// into queues, an independent monitor compares them as the DUT presents them.
module tb_shm_dma_requester;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_ptr;
  logic [3:0] cmd_start;
  logic [3:0] cmd_length;
  logic       done_valid;
  logic       done_timeout;
  logic       busy;
  logic       protocol_err;
  logic       trigger;
  logic       ack;
  logic       action;
  logic [3:0] ptr;
  logic [3:0] copy_start;
  logic [3:0] copy_length;

  always #5 clock = ~clock;

  shm_dma_requester #(
    .SIZE           (4),
    .PROCSIZE       (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_ptr      (cmd_ptr),
    .cmd_start    (cmd_start),
    .cmd_length   (cmd_length),
    .done_valid   (done_valid),
    .done_timeout (done_timeout),
    .busy         (busy),
    .protocol_err (protocol_err),
    .trigger      (trigger),
    .ack          (ack),
    .action       (action),
    .ptr          (ptr),
    .copy_start   (copy_start),
    .copy_length  (copy_length)
  );

  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          trig_cnt = 0;
  int          done_cnt = 0;
  logic        trig_prev = 1'b0;
  logic [12:0] req_q[$];
  logic        done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        trig_prev = 1'b0;
      end else begin
        if (trigger !== trig_prev) begin
          trig_prev = trigger;
          trig_cnt++;
          check("trigger_expected", (req_q.size() != 0), 1);
          if (req_q.size() != 0)
            check("req_fields", {action, ptr, copy_start, copy_length}, req_q.pop_front());
        end
        if (done_valid) begin
          done_cnt++;
          check("done_expected", (done_q.size() != 0), 1);
          if (done_q.size() != 0)
            check("done_timeout", done_timeout, done_q.pop_front());
        end
      end
    end
  end

  task automatic push(input logic w, input logic [3:0] p, input logic [3:0] s,
                      input logic [3:0] l, input logic to);
    int g = 0;
    while (!cmd_ready && g < 200) begin
      cmd_valid = 1'b0;
      @(negedge clock);
      g++;
    end
    check("push_ready", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_write  = w;
    cmd_ptr    = p;
    cmd_start  = s;
    cmd_length = l;
    if (l != 4'd0) req_q.push_back({w, p, s, l});
    done_q.push_back(to);
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_for(input bit on_done, input int target, input string nm, output int cyc);
    cyc = 0;
    while ((on_done ? done_cnt : trig_cnt) < target && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check({nm, "_reached"}, ((on_done ? done_cnt : trig_cnt) >= target), 1);
  endtask

  int cyc;
  int tb_base;
  int db_base;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_ptr = 4'd0; cmd_start = 4'd0; cmd_length = 4'd0; ack = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_trigger", trigger, 0);
    check("rst_fields", {action, ptr, copy_start, copy_length}, 0);
    check("rst_done", {done_valid, done_timeout}, 0);
    check("rst_perr", protocol_err, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);

    // Store, ack six cycles after the request.
    push(1'b1, 4'h4, 4'h2, 4'h3, 1'b0);
    wait_for(1'b0, 1, "store_trig", cyc);
    check("store_trig_latency", cyc, 1);
    check("store_trigger", trigger, 1);
    repeat (6) @(negedge clock);
    ack = ~ack;
    wait_for(1'b1, 1, "store_done", cyc);
    check("store_done_latency", cyc, 1);
    @(negedge clock);
    check("store_idle", busy, 0);

    // Back-to-back: FIFO fills, fourth command waits for space.
    tb_base = trig_cnt;
    db_base = done_cnt;
    push(1'b0, 4'h1, 4'h5, 4'h2, 1'b0);
    push(1'b1, 4'h8, 4'h0, 4'h4, 1'b0);
    push(1'b0, 4'hC, 4'h9, 4'h1, 1'b0);
    check("b2b_full", cmd_ready, 0);
    for (int k = 0; k < 4; k++) begin
      wait_for(1'b0, tb_base + 1 + k, "b2b_trig", cyc);
      repeat (3) @(negedge clock);
      ack = ~ack;
      if (k < 3) begin
        wait_for(1'b0, tb_base + 2 + k, "b2b_next", cyc);
        check("b2b_next_latency", cyc, 2);
      end
      if (k == 0) begin
        check("b2b_space", cmd_ready, 1);
        push(1'b1, 4'hF, 4'h3, 4'h7, 1'b0);
      end
    end
    wait_for(1'b1, db_base + 4, "b2b_done", cyc);
    @(negedge clock);

    // Timeout then drain, then a normal request.
    db_base = done_cnt;
    push(1'b0, 4'h3, 4'h7, 4'h5, 1'b1);
    wait_for(1'b0, trig_cnt + 1, "to_trig", cyc);
    wait_for(1'b1, db_base + 1, "to_done", cyc);
    check("to_latency", cyc, 9);
    check("to_drain_busy", busy, 1);
    tb_base = trig_cnt;
    repeat (4) @(negedge clock);
    check("to_drain_hold", busy, 1);
    check("to_no_retrigger", trig_cnt, tb_base);
    ack = ~ack;
    repeat (2) @(negedge clock);
    check("to_drain_exit", busy, 0);
    check("to_no_second_done", done_cnt, db_base + 1);
    push(1'b1, 4'h2, 4'h3, 4'h6, 1'b0);
    wait_for(1'b0, tb_base + 1, "post_to_trig", cyc);
    repeat (2) @(negedge clock);
    ack = ~ack;
    wait_for(1'b1, db_base + 2, "post_to_done", cyc);

    // Ack on the exact timeout cycle wins.
    db_base = done_cnt;
    push(1'b0, 4'h9, 4'h1, 4'h7, 1'b0);
    wait_for(1'b0, trig_cnt + 1, "race_trig", cyc);
    repeat (8) @(negedge clock);
    ack = ~ack;
    wait_for(1'b1, db_base + 1, "race_done", cyc);
    check("race_latency", cyc, 1);
    check("race_no_drain", busy, 0);

    // Zero-length command and spurious ack in IDLE.
    tb_base = trig_cnt;
    db_base = done_cnt;
    push(1'b1, 4'h5, 4'h6, 4'h0, 1'b0);
    wait_for(1'b1, db_base + 1, "zero_done", cyc);
    check("zero_latency", cyc, 1);
    check("zero_no_trigger", trig_cnt, tb_base);
    check("perr_clear", protocol_err, 0);
    ack = ~ack;
    repeat (2) @(negedge clock);
    check("perr_set", protocol_err, 1);
    repeat (5) @(negedge clock);
    check("perr_sticky", protocol_err, 1);
    check("spurious_no_done", done_cnt, db_base + 1);

    // Reset in the middle of WAIT with a second command queued.
    push(1'b0, 4'h7, 4'h2, 4'h3, 1'b0);
    push(1'b0, 4'h1, 4'h1, 4'h1, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    ack   = 1'b0;
    #1;
    check("mid_rst_trigger", trigger, 0);
    check("mid_rst_fields", {action, ptr, copy_start, copy_length}, 0);
    check("mid_rst_done", {done_valid, done_timeout}, 0);
    check("mid_rst_perr", protocol_err, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_busy", busy, 0);
    req_q.delete();
    done_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    tb_base = trig_cnt;
    db_base = done_cnt;
    push(1'b1, 4'hA, 4'hB, 4'hC, 1'b0);
    wait_for(1'b0, tb_base + 1, "fresh_trig", cyc);
    check("fresh_trigger", trigger, 1);
    repeat (2) @(negedge clock);
    ack = ~ack;
    wait_for(1'b1, db_base + 1, "fresh_done", cyc);
    repeat (5) @(negedge clock);
    check("fresh_no_stale", trig_cnt, tb_base + 1);
    check("req_q_empty", req_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
